// File: rtl/pc_stack.sv
// Program counter with a hardware call/return stack, depth/full/empty status and a sticky fault flag.
// Optional build macro PC_STACK_TRAP_EN: stack faults jump to TRAP_VECTOR instead of in/hold.
module pc_stack #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = '1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       inc,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           in,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_nxt;
  logic [DW-1:0]    depth_nxt;
  logic             err_nxt;
  logic             push;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pc_inc = out + WIDTH'(1);
  assign full   = (depth == DW'(DEPTH));
  assign empty  = (depth == '0);
  // depth < DEPTH whenever wr_ptr is used, so the low bits address the entry directly
  assign wr_ptr = depth[AW-1:0];
  assign rd_ptr = wr_ptr - AW'(1);

  always_comb begin
    pc_nxt    = out;
    depth_nxt = depth;
    err_nxt   = err;
    push      = 1'b0;
    if (call) begin
      if (!full) begin
        push      = 1'b1;
        depth_nxt = depth + DW'(1);
        pc_nxt    = in;
      end else begin
        err_nxt = 1'b1;
`ifdef PC_STACK_TRAP_EN
        pc_nxt  = TRAP_VECTOR;
`else
        pc_nxt  = in;
`endif
      end
    end else if (ret) begin
      if (!empty) begin
        depth_nxt = depth - DW'(1);
        pc_nxt    = stack_mem[rd_ptr];
      end else begin
        err_nxt = 1'b1;
`ifdef PC_STACK_TRAP_EN
        pc_nxt  = TRAP_VECTOR;
`endif
      end
    end else if (load) begin
      pc_nxt = in;
    end else if (inc) begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out   <= RESET_VECTOR;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      out   <= pc_nxt;
      depth <= depth_nxt;
      err   <= err_nxt;
    end
  end

  // Entry storage carries no reset; depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_ptr] <= pc_inc;
  end

endmodule
